// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer: state encoding and parameter defaults.
package mem_pkg;

  localparam int unsigned ADDR_BITS_DEF  = 9;
  localparam int unsigned RD_LATENCY_DEF = 1;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg32.sv
// 32-bit register with synchronous clear (priority) and load enable.
module reg32 (
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_seq.sv
// Sequences one RAM write or read from MAR/MDR; read data is captured back into MDR.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] BusMuxOut,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] Mdatain,
  output logic [31:0] Address_Signal,
  output logic [31:0] Data_Signal,
  output logic        Read,
  output logic        Write,
  output logic [31:0] BusMuxIn_MDR,
  output logic        busy,
  output logic        done
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               read_d, write_d, done_d, busy_d;
  logic [DATA_W-1:0]  mar, mdr, mdr_d;
  logic               mar_load, mdr_load, rd_last;
  logic               unused_mar_bits;

  assign rd_last  = (state == READ) && (cnt == CNT_W'(RD_LATENCY - 1));
  assign mar_load = (state == IDLE) && MARin;
  assign mdr_load = ((state == IDLE) && MDRin) || rd_last;
  assign mdr_d    = rd_last ? Mdatain : BusMuxOut;

  reg32 u_mar (.clk(clk), .clear(reset), .load(mar_load), .d(BusMuxOut), .q(mar));
  reg32 u_mdr (.clk(clk), .clear(reset), .load(mdr_load), .d(mdr_d),     .q(mdr));

  // State, read counter and strobes share one register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      Read  <= 1'b0;
      Write <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      Read  <= read_d;
      Write <= write_d;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    unique case (state)
      IDLE:  if (mem_req) state_next = mem_wr ? WRITE : READ;
      WRITE: state_next = DONE;
      READ: begin
        if (rd_last) state_next = DONE;
        else         cnt_next   = cnt + CNT_W'(1);
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so they register in step with it.
  always_comb begin
    read_d  = (state_next == READ);
    write_d = (state_next == WRITE);
    done_d  = (state_next == DONE);
    busy_d  = (state_next != IDLE);
  end

  assign Address_Signal  = DATA_W'(mar[ADDR_BITS-1:0]);
  assign Data_Signal     = mdr;
  assign BusMuxIn_MDR    = mdr;
  assign unused_mar_bits = ^mar;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq with ADDR_BITS=9, RD_LATENCY=3.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, mem_req, mem_wr;
  logic [31:0] Mdatain;
  logic [31:0] Address_Signal, Data_Signal, BusMuxIn_MDR;
  logic        Read, Write, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_seq #(.ADDR_BITS(9), .RD_LATENCY(3)) dut (
    .clk(clk), .reset(reset), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .mem_req(mem_req), .mem_wr(mem_wr), .Mdatain(Mdatain),
    .Address_Signal(Address_Signal), .Data_Signal(Data_Signal), .Read(Read),
    .Write(Write), .BusMuxIn_MDR(BusMuxIn_MDR), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; mem_req = 0; mem_wr = 0;
    Mdatain = '0;
    step(); step();
    reset = 1'b0;
    check("rst_read",  32'(Read),  0);
    check("rst_write", 32'(Write), 0);
    check("rst_done",  32'(done),  0);
    check("rst_busy",  32'(busy),  0);
    check("rst_mdr",   BusMuxIn_MDR, 0);
    check("rst_addr",  Address_Signal, 0);

    // Write transaction
    MARin = 1; BusMuxOut = 32'h0000_0005; step();
    MARin = 0; MDRin = 1; BusMuxOut = 32'h1234_5678; step();
    MDRin = 0; mem_req = 1; mem_wr = 1; step();
    mem_req = 0; mem_wr = 0;
    check("wr_write", 32'(Write), 1);
    check("wr_read",  32'(Read),  0);
    check("wr_busy",  32'(busy),  1);
    check("wr_addr",  Address_Signal, 32'h0000_0005);
    check("wr_data",  Data_Signal, 32'h1234_5678);
    step();
    check("wr_done",     32'(done),  1);
    check("wr_done_wr",  32'(Write), 0);
    check("wr_done_busy",32'(busy),  1);
    step();
    check("wr_idle_done", 32'(done), 0);
    check("wr_idle_busy", 32'(busy), 0);

    // Truncated address, then read with a busy-time MDRin that must be ignored
    MARin = 1; BusMuxOut = 32'hFFFF_FE05; step();
    MARin = 0;
    check("trunc_addr", Address_Signal, 32'h0000_0005);
    mem_req = 1; mem_wr = 0; step();
    mem_req = 0;
    check("rd_c1_read",  32'(Read),  1);
    check("rd_c1_write", 32'(Write), 0);
    MDRin = 1; BusMuxOut = 32'hFFFF_FFFF; Mdatain = 32'hDEAD_BEEF; step();
    check("rd_c2_read", 32'(Read), 1);
    check("rd_c2_mdr",  BusMuxIn_MDR, 32'h1234_5678);
    step();
    check("rd_c3_read", 32'(Read), 1);
    check("rd_c3_done", 32'(done), 0);
    step();
    MDRin = 0;
    check("rd_done",      32'(done), 1);
    check("rd_done_read", 32'(Read), 0);
    check("rd_mdr",       BusMuxIn_MDR, 32'hDEAD_BEEF);
    step();
    check("rd_idle_busy", 32'(busy), 0);

    // Same-cycle MAR load and request
    MARin = 1; BusMuxOut = 32'h0000_000A; mem_req = 1; mem_wr = 1; step();
    MARin = 0; mem_req = 0; mem_wr = 0;
    check("same_write", 32'(Write), 1);
    check("same_addr",  Address_Signal, 32'h0000_000A);
    check("same_data",  Data_Signal, 32'hDEAD_BEEF);
    step(); step();

    // Request held through DONE restarts only from the following IDLE
    mem_req = 1; mem_wr = 1; step();
    check("hold_write", 32'(Write), 1);
    step();
    check("hold_done", 32'(done), 1);
    step();
    check("hold_idle_busy",  32'(busy),  0);
    check("hold_idle_write", 32'(Write), 0);
    step();
    mem_req = 0; mem_wr = 0;
    check("hold_rewrite", 32'(Write), 1);
    step(); step();

    // Reset in the second READ cycle
    Mdatain = 32'hCAFE_F00D;
    mem_req = 1; mem_wr = 0; step();
    mem_req = 0;
    check("rr_c1_read", 32'(Read), 1);
    step();
    check("rr_c2_read", 32'(Read), 1);
    reset = 1; step();
    reset = 0;
    check("rr_read", 32'(Read), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_mdr",  BusMuxIn_MDR, 0);
    check("rr_done", 32'(done), 0);
    check("rr_addr", Address_Signal, 0);
    step();
    check("rr_no_done", 32'(done), 0);
    step();
    check("rr_no_done2", 32'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 Parameter ADDR_BITS, default 9, number of MAR bits forwarded to the RAM address.
REQ-002 Parameter RD_LATENCY, default 1, cycles Read is held before Mdatain is valid; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 BusMuxOut  in  32  CPU bus value, source for MAR/MDR loads.
REQ-006 MARin  in  1  load MAR from BusMuxOut.
REQ-007 MDRin  in  1  load MDR from BusMuxOut.
REQ-008 mem_req  in  1  start a memory transaction.
REQ-009 mem_wr  in  1  transaction type, sampled with mem_req: 1 write, 0 read.
REQ-010 Mdatain  in  32  read data returned by RAM.
REQ-011 Address_Signal  out  32  RAM address: MAR[ADDR_BITS-1:0], upper bits zero.
REQ-012 Data_Signal  out  32  RAM write data, always equal to MDR.
REQ-013 Read  out  1  RAM read strobe.
REQ-014 Write  out  1  RAM write strobe.
REQ-015 BusMuxIn_MDR  out  32  MDR contents toward the bus mux.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, WRITE, READ, DONE; Read, Write, done SHALL be registered, decoded from state only.
REQ-019 In IDLE, MARin/MDRin SHALL load MAR/MDR at the edge; MARin and MDRin are independent and may both assert.
REQ-020 In IDLE, mem_req=1 SHALL latch mem_wr and move to WRITE (mem_wr=1) or READ (mem_wr=0) at the same edge.
REQ-021 MARin/MDRin in the same cycle as mem_req SHALL load first-effective; the transaction SHALL use the newly loaded values.
REQ-022 WRITE SHALL last exactly 1 cycle with Write=1, then go to DONE.
REQ-023 READ SHALL last exactly RD_LATENCY cycles with Read=1; a 4-bit counter tracks cycles.
REQ-024 On the edge ending the last READ cycle, MDR SHALL load Mdatain, then go to DONE.
REQ-025 DONE SHALL last 1 cycle with done=1, busy=1, then return to IDLE.
REQ-026 Read latency req-edge to done: RD_LATENCY+1 cycles; write: 2 cycles.
REQ-027 While busy, mem_req, MARin, MDRin SHALL be ignored; MAR/MDR hold except the REQ-024 capture.
REQ-028 Read and Write SHALL never be high in the same cycle.
REQ-029 mem_req held high through DONE SHALL start a new transaction only from the following IDLE cycle.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, MAR=0, MDR=0, counter=0, Read=Write=done=busy=0, aborting any transaction, with priority over all inputs.

Structure
REQ-031 Shared package mem_pkg SHALL hold the state encoding, ADDR_BITS default, and RD_LATENCY default.
REQ-032 MAR and MDR SHALL be instances of a sub-module reg32 (32-bit register, synchronous clear, load enable).

Verification
REQ-033 Write: load MAR=0x05, MDR=0x12345678, req wr=1 -> Write=1 one cycle with Address=0x05, Data=0x12345678; done next cycle.
REQ-034 Read: MAR=0x05, req wr=0, RAM returns 0xDEADBEEF -> Read=1 for RD_LATENCY cycles, BusMuxIn_MDR=0xDEADBEEF at done.
REQ-035 Truncation: MAR=0xFFFFFE05, ADDR_BITS=9 -> Address_Signal=0x00000005.
REQ-036 Same-cycle: MARin=1 with BusMuxOut=0x0A and mem_req=1 -> Write cycle shows Address=0x0A.
REQ-037 Ignore-when-busy: MDRin=1 with 0xFFFFFFFF during READ -> MDR ends with Mdatain, not 0xFFFFFFFF.
REQ-038 Reset mid-read (RD_LATENCY=3, reset in 2nd READ cycle) -> next cycle Read=0, busy=0, MDR=0, no done pulse.
